// File: rtl/morse_letter_decoder.sv
// Morse letter decoder: accumulates up to five dot/dash symbols and, after an
// inter-letter silence, emits the 7-bit ASCII character with a one-cycle strobe.
// Optional feature macro: MORSE_WORD_GAP_EN (adds WORD_WAIT and the 0x20 space strobe).
module morse_letter_decoder #(
    parameter int unsigned LETTER_GAP = 9,
    parameter int unsigned WORD_GAP   = 21
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_pressed,
    input  logic       i_dot,
    input  logic       i_dash,
    output logic [6:0] o_char_code,
    output logic       o_char_valid,
    output logic       o_char_error
);

    localparam int unsigned CntW = $clog2(WORD_GAP + 1);
    localparam logic [CntW-1:0] WordGapCnt    = CntW'(WORD_GAP);
    localparam logic [CntW-1:0] LetterGapM1   = CntW'(LETTER_GAP - 1);
    localparam logic [CntW-1:0] WordGapM1     = CntW'(WORD_GAP - 1);

`ifdef MORSE_WORD_GAP_EN
    typedef enum logic [1:0] {StIdle, StCollect, StWordWait} state_e;
`else
    typedef enum logic [1:0] {StIdle, StCollect} state_e;
`endif

    state_e          r_state;
    logic [4:0]      r_pattern;
    logic [2:0]      r_len;
    logic            r_overflow;
    logic [CntW-1:0] r_idle_cnt;

    logic            w_sym;
    logic            w_quiet;
    logic            w_reach_letter;
    logic            w_reach_word;
    logic [4:0]      w_app_pattern;
    logic [2:0]      w_app_len;
    logic            w_app_ovf;
    logic [7:0]      w_lookup;

    // ITU lookup keyed on (len, pattern); returns {error, ascii}.
    function automatic logic [7:0] lookup(input logic [2:0] len, input logic [4:0] pat,
                                          input logic ovf);
        logic [7:0] res;
        unique case ({len, pat})
            8'b001_00000: res = {1'b0, 7'h45}; // E
            8'b001_00001: res = {1'b0, 7'h54}; // T
            8'b010_00000: res = {1'b0, 7'h49}; // I
            8'b010_00001: res = {1'b0, 7'h41}; // A
            8'b010_00010: res = {1'b0, 7'h4E}; // N
            8'b010_00011: res = {1'b0, 7'h4D}; // M
            8'b011_00000: res = {1'b0, 7'h53}; // S
            8'b011_00001: res = {1'b0, 7'h55}; // U
            8'b011_00010: res = {1'b0, 7'h52}; // R
            8'b011_00011: res = {1'b0, 7'h57}; // W
            8'b011_00100: res = {1'b0, 7'h44}; // D
            8'b011_00101: res = {1'b0, 7'h4B}; // K
            8'b011_00110: res = {1'b0, 7'h47}; // G
            8'b011_00111: res = {1'b0, 7'h4F}; // O
            8'b100_00000: res = {1'b0, 7'h48}; // H
            8'b100_00001: res = {1'b0, 7'h56}; // V
            8'b100_00010: res = {1'b0, 7'h46}; // F
            8'b100_00100: res = {1'b0, 7'h4C}; // L
            8'b100_00110: res = {1'b0, 7'h50}; // P
            8'b100_00111: res = {1'b0, 7'h4A}; // J
            8'b100_01000: res = {1'b0, 7'h42}; // B
            8'b100_01001: res = {1'b0, 7'h58}; // X
            8'b100_01010: res = {1'b0, 7'h43}; // C
            8'b100_01011: res = {1'b0, 7'h59}; // Y
            8'b100_01100: res = {1'b0, 7'h5A}; // Z
            8'b100_01101: res = {1'b0, 7'h51}; // Q
            8'b101_01111: res = {1'b0, 7'h31}; // 1
            8'b101_00111: res = {1'b0, 7'h32}; // 2
            8'b101_00011: res = {1'b0, 7'h33}; // 3
            8'b101_00001: res = {1'b0, 7'h34}; // 4
            8'b101_00000: res = {1'b0, 7'h35}; // 5
            8'b101_10000: res = {1'b0, 7'h36}; // 6
            8'b101_11000: res = {1'b0, 7'h37}; // 7
            8'b101_11100: res = {1'b0, 7'h38}; // 8
            8'b101_11110: res = {1'b0, 7'h39}; // 9
            8'b101_11111: res = {1'b0, 7'h30}; // 0
            default:      res = {1'b1, 7'h3F}; // '?'
        endcase
        if (ovf) begin
            res = {1'b1, 7'h3F};
        end
        return res;
    endfunction

    // Decode input activity, gap thresholds and the appended buffer value.
    always_comb begin
        w_sym          = i_dot | i_dash;
        w_quiet        = !i_pressed && !w_sym;
        // Threshold fires on the edge at which the count would land on the gap value.
        w_reach_letter = w_quiet && (r_idle_cnt == LetterGapM1);
        w_reach_word   = w_quiet && (r_idle_cnt == WordGapM1);
        w_app_pattern  = r_pattern;
        w_app_len      = r_len;
        w_app_ovf      = r_overflow;
        if (r_len == 3'd5) begin
            w_app_ovf = 1'b1;
        end else begin
            w_app_pattern = {r_pattern[3:0], i_dash};
            w_app_len     = r_len + 3'd1;
        end
        w_lookup       = lookup(r_len, r_pattern, r_overflow);
    end

    // Idle counter: counts silent edges, saturating at WORD_GAP.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_idle_cnt <= '0;
        end else if (!w_quiet) begin
            r_idle_cnt <= '0;
        end else if (r_idle_cnt != WordGapCnt) begin
            r_idle_cnt <= r_idle_cnt + 1'b1;
        end
    end

    // Letter FSM with symbol buffer and registered output strobe.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state      <= StIdle;
            r_pattern    <= '0;
            r_len        <= '0;
            r_overflow   <= 1'b0;
            o_char_code  <= '0;
            o_char_valid <= 1'b0;
            o_char_error <= 1'b0;
        end else begin
            o_char_code  <= '0;
            o_char_valid <= 1'b0;
            o_char_error <= 1'b0;
            case (r_state)
                StIdle: begin
                    if (w_sym) begin
                        r_pattern  <= {4'b0, i_dash};
                        r_len      <= 3'd1;
                        r_overflow <= 1'b0;
                        r_state    <= StCollect;
                    end
                end
                StCollect: begin
                    if (w_sym) begin
                        r_pattern  <= w_app_pattern;
                        r_len      <= w_app_len;
                        r_overflow <= w_app_ovf;
                    end else if (w_reach_letter) begin
                        o_char_code  <= w_lookup[6:0];
                        o_char_error <= w_lookup[7];
                        o_char_valid <= 1'b1;
                        r_pattern    <= '0;
                        r_len        <= '0;
                        r_overflow   <= 1'b0;
`ifdef MORSE_WORD_GAP_EN
                        r_state      <= StWordWait;
`else
                        r_state      <= StIdle;
`endif
                    end
                end
`ifdef MORSE_WORD_GAP_EN
                StWordWait: begin
                    if (w_sym) begin
                        r_pattern  <= {4'b0, i_dash};
                        r_len      <= 3'd1;
                        r_overflow <= 1'b0;
                        r_state    <= StCollect;
                    end else if (i_pressed) begin
                        r_state <= StIdle;
                    end else if (w_reach_word) begin
                        o_char_code  <= 7'h20;
                        o_char_valid <= 1'b1;
                        r_state      <= StIdle;
                    end
                end
`endif
                default: r_state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_morse_letter_decoder.sv
// Self-checking bench for morse_letter_decoder: table of letters plus hand-written
// sequences for gap-edge races, word gap suppression and asynchronous reset.
module tb_morse_letter_decoder;

    localparam int unsigned LG = 9;
    localparam int unsigned WG = 21;
`ifdef MORSE_WORD_GAP_EN
    localparam bit WordEn = 1'b1;
`else
    localparam bit WordEn = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       pressed;
    logic       dot;
    logic       dash;
    logic [6:0] char_code;
    logic       char_valid;
    logic       char_error;

    morse_letter_decoder #(
        .LETTER_GAP(LG),
        .WORD_GAP  (WG)
    ) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_pressed   (pressed),
        .i_dot       (dot),
        .i_dash      (dash),
        .o_char_code (char_code),
        .o_char_valid(char_valid),
        .o_char_error(char_error)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         at;
        logic [6:0] code;
        logic       err;
    } strobe_t;

    typedef struct {
        int         n;
        logic [5:0] syms;
        logic [6:0] code;
        logic       err;
    } vec_t;

    strobe_t got[$];
    strobe_t exp[$];
    int      cyc = 0;
    int      total = 0;
    int      bad = 0;
    int      consec = 0;
    int      junk = 0;
    logic    prev_valid = 1'b0;

    // Edge counter and strobe recorder, sampled 1 time unit after each rising edge.
    always @(posedge clk) begin
        cyc = cyc + 1;
        #1;
        if (char_valid === 1'b1) got.push_back('{cyc, char_code, char_error});
        if (char_valid === 1'b1 && prev_valid === 1'b1) consec++;
        if (char_valid !== 1'b1 && (char_code !== 7'h00 || char_error !== 1'b0)) junk++;
        prev_valid = char_valid;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    task automatic check_strobes(input string name);
        check({name, " count"}, got.size(), exp.size());
        for (int i = 0; i < exp.size(); i++) begin
            if (i < got.size()) begin
                check({name, " edge"}, got[i].at, exp[i].at);
                check({name, " code"}, got[i].code, exp[i].code);
                check({name, " err"}, got[i].err, exp[i].err);
            end
        end
        got.delete();
        exp.delete();
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // One-cycle symbol pulse; returns the edge index at which it was sampled.
    task automatic pulse(input logic d, output int at);
        @(negedge clk);
        dot  = ~d;
        dash = d;
        @(negedge clk);
        dot  = 1'b0;
        dash = 1'b0;
        at   = cyc;
    endtask

    task automatic press_one(output int at);
        @(negedge clk);
        pressed = 1'b1;
        @(negedge clk);
        pressed = 1'b0;
        at      = cyc;
    endtask

    task automatic send(input int n, input logic [5:0] syms, output int last);
        for (int i = 0; i < n; i++) begin
            pulse(syms[n-1-i], last);
            if (i != n - 1) idle(2);
        end
    endtask

    task automatic expect_letter(input int last, input logic [6:0] code, input logic err);
        exp.push_back('{last + LG, code, err});
        if (WordEn) exp.push_back('{last + WG, 7'h20, 1'b0});
    endtask

    vec_t vecs[10];
    int   last;
    int   t0;

    initial begin
        vecs[0] = '{2, 6'b000001, 7'h41, 1'b0}; // A
        vecs[1] = '{5, 6'b011111, 7'h30, 1'b0}; // 0
        vecs[2] = '{4, 6'b000011, 7'h3F, 1'b1}; // ..-- unassigned
        vecs[3] = '{6, 6'b000000, 7'h3F, 1'b1}; // overflow
        vecs[4] = '{1, 6'b000001, 7'h54, 1'b0}; // T after overflow
        vecs[5] = '{1, 6'b000000, 7'h45, 1'b0}; // E
        vecs[6] = '{3, 6'b000111, 7'h4F, 1'b0}; // O
        vecs[7] = '{5, 6'b000000, 7'h35, 1'b0}; // 5
        vecs[8] = '{4, 6'b001100, 7'h5A, 1'b0}; // Z
        vecs[9] = '{5, 6'b001111, 7'h31, 1'b0}; // 1

        rst     = 1'b1;
        pressed = 1'b0;
        dot     = 1'b0;
        dash    = 1'b0;

        // Symbols during reset must be ignored.
        pulse(1'b0, t0);
        pulse(1'b1, t0);
        pulse(1'b0, t0);
        check("reset valid", char_valid, 1'b0);
        check("reset code", char_code, 7'h00);
        check("reset err", char_error, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        idle(30);
        check_strobes("post-reset quiet");

        foreach (vecs[k]) begin
            send(vecs[k].n, vecs[k].syms, last);
            expect_letter(last, vecs[k].code, vecs[k].err);
            idle(WG + 4);
            check_strobes($sformatf("vec%0d", k));
        end

        // Dot and dash together count as a dash.
        @(negedge clk);
        dot  = 1'b1;
        dash = 1'b1;
        @(negedge clk);
        dot  = 1'b0;
        dash = 1'b0;
        last = cyc;
        expect_letter(last, 7'h54, 1'b0);
        idle(WG + 4);
        check_strobes("dot+dash");

        // Dash lands exactly on the letter-gap edge: appended, letter becomes A.
        pulse(1'b0, t0);
        idle(LG - 2);
        pulse(1'b1, last);
        expect_letter(last, 7'h41, 1'b0);
        idle(WG + 4);
        check_strobes("dash on gap edge");

        // Pressed on the letter-gap edge delays the emit.
        pulse(1'b0, t0);
        idle(LG - 2);
        press_one(last);
        expect_letter(last, 7'h45, 1'b0);
        idle(WG + 4);
        check_strobes("press on gap edge");

        // Pressed during the word wait suppresses the space.
        pulse(1'b0, last);
        idle(13);
        press_one(t0);
        exp.push_back('{last + LG, 7'h45, 1'b0});
        idle(WG + 4);
        check_strobes("press cancels space");

        // Reset while the strobe is high drops outputs at once and cancels the space.
        pulse(1'b1, last);
        idle(LG - 1);
        @(posedge clk);
        #2;
        check("strobe before reset", char_valid, 1'b1);
        rst = 1'b1;
        #1;
        check("async reset valid", char_valid, 1'b0);
        check("async reset code", char_code, 7'h00);
        @(negedge clk);
        rst = 1'b0;
        exp.push_back('{last + LG, 7'h54, 1'b0});
        idle(WG + 4);
        check_strobes("reset on strobe");

        // Reset mid-letter discards the buffer; the next letter decodes cleanly.
        send(2, 6'b000001, last);
        idle(2);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        idle(WG + 4);
        check_strobes("mid-letter reset");
        send(2, 6'b000010, last);
        expect_letter(last, 7'h4E, 1'b0);
        idle(WG + 4);
        check_strobes("after reset N");

        check("no back-to-back strobes", consec, 0);
        check("code zero when not valid", junk, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/morse_letter_decoder.md
# morse_letter_decoder

Downstream of the dot/dash key parser. Consumes its single-cycle dot/dash pulses plus the synchronized key-pressed level and accumulates up to five symbols. On an inter-letter silence it looks up the symbol sequence and emits a 7-bit ASCII character with a one-cycle valid strobe. Output feeds the character display/buffer stage.

## Interface
- LETTER_GAP, 9: consecutive idle cycles after the last symbol that close a letter; legal range 2..WORD_GAP-1.
- WORD_GAP, 21: idle cycles after the last symbol that produce a space; used only with the word-gap feature.
- Clock  input  1  system clock; all state changes on its rising edge.
- Reset  input  1  asynchronous, active-high; clears all state immediately.
- pressed  input  1  synchronized key-down level; high while the key is held.
- dot  input  1  one-cycle pulse for a completed dot.
- dash  input  1  one-cycle pulse for a completed dash.
- charCode  output  7  ASCII code, valid only while charValid is high; 0x00 otherwise.
- charValid  output  1  one-cycle strobe; charCode is presented.
- charError  output  1  high with charValid when the sequence is unrecognized or overlong.

## Operation
- Symbol buffer:
  - 5-bit pattern, shifted left; the new symbol enters the LSB; dash=1, dot=0.
  - 3-bit length.
  - Sticky overflow flag, set when a sixth or later symbol arrives; the pattern stops shifting at 5.
- dot and dash high together count as a dash.
- Idle counter:
  - Increments on each edge with pressed=0 and no dot/dash.
  - Cleared on any edge with pressed=1 or a dot/dash pulse.
  - Saturates at WORD_GAP; width $clog2(WORD_GAP+1).
- States:
  - IDLE: empty buffer. A dot/dash loads the buffer (len=1) and moves to COLLECT.
  - COLLECT: a dot/dash appends and increments len. When the idle counter reaches LETTER_GAP, one character is emitted, the buffer clears, and the state moves to WORD_WAIT if WORD_GAP support is enabled, else to IDLE.
  - WORD_WAIT: pressed returns to IDLE with no space. A dot/dash loads the buffer and moves to COLLECT. Idle count reaching WORD_GAP emits 0x20 and returns to IDLE.
- Lookup: full ITU table for A–Z and 0–9 keyed on (len, pattern).
  - Examples: E(1,0)=0x45; T(1,1)=0x54; A(2,01)=0x41; S(3,000)=0x53; O(3,111)=0x4F; 5(5,00000)=0x35; 0(5,11111)=0x30.
  - Unassigned codes or overflow give charCode=0x3F ('?') and charError=1.
- Reset values: charCode=0x00, charValid=0, charError=0, state IDLE, buffer/len/overflow/idle counter all 0.

## Timing
- All outputs are registered.
- If the last symbol pulse is sampled at edge N and there is no further activity, charValid is high from edge N+LETTER_GAP to edge N+LETTER_GAP+1.
- A space strobe goes high at edge N+WORD_GAP.
- A dot/dash on the same edge at which the count would reach LETTER_GAP wins. The symbol is appended, the counter clears, and no character is emitted.
- pressed high on that edge also clears the counter, so no emit occurs.
- charValid is never high on two consecutive cycles.
- Reset asserted mid-letter discards the buffer without emitting. Outputs drop to their reset values asynchronously.
- There is no backpressure; the consumer must accept each strobe.

## Configuration
- MORSE_WORD_GAP_EN defined: WORD_WAIT state present. One 0x20 strobe follows each letter when silence reaches WORD_GAP.
- MORSE_WORD_GAP_EN undefined: WORD_WAIT absent; COLLECT returns to IDLE after the emit, and 0x20 is never produced. WORD_GAP is ignored.

## Test plan
- Reset with dot pulses applied -> all outputs 0; after release, no strobe until input activity.
- Dot at edge 10, dash at edge 14, then idle (LETTER_GAP=9) -> charValid=1 and charCode=0x41 at edge 23 only; charError=0.
- Five dashes, then idle -> 0x30. Dot–dot–dash–dash, then idle -> charCode 0x3F with charError=1.
- Six dots -> 0x3F with charError=1. A following single dash letter -> 0x54, confirming the overflow flag cleared.
- With MORSE_WORD_GAP_EN defined, a single dot at edge 5 -> 0x45 at edge 14, then 0x20 at edge 26.
  - Repeat with pressed high at edge 20 -> no space.
  - Without the macro -> no space ever.
- Dash pulse landing exactly on the LETTER_GAP edge -> no emit; the letter grows. Reset asserted mid-letter -> no strobe, and the next letter decodes cleanly.
